// File: rtl/fir_decim_fifo.sv
// Decimating requantiser with a show-ahead output FIFO.
// Keeps every DECIM-th input sample, rounds and saturates it to OUT_W bits,
// stages it for one cycle and then writes it into a DEPTH-word FIFO.
// A write that finds the FIFO full is dropped; this is recorded by the
// sticky overflow flag and a saturating drop counter.
module fir_decim_fifo #(
    parameter int unsigned DATA_W = 15,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned SHIFT  = 7,
    parameter int unsigned DECIM  = 2,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      valid_in,
    output logic [OUT_W-1:0]          data_out,
    output logic                      valid_out,
    input  logic                      ready_in,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      overflow,
    output logic [7:0]                drop_cnt
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned LW   = AW + 1;
    localparam int unsigned PW   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned SW   = DATA_W + 1;
    localparam int unsigned RND  = (SHIFT == 0) ? 0 : (32'd1 << (SHIFT - 1));
    localparam int unsigned MAXV = (32'd1 << OUT_W) - 1;

    logic [PW-1:0]    phase_q, phase_d;
    logic             stg_vld_q, stg_vld_d;
    logic [OUT_W-1:0] stg_data_q, stg_data_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       drop_q, drop_d;
    logic [OUT_W-1:0] head_q, head_d;
    logic [OUT_W-1:0] mem_q [DEPTH];

    logic [SW-1:0]    sum;
    logic [SW-1:0]    rq;
    logic [OUT_W-1:0] q_res;
    logic             keep;
    logic             pop;
    logic             wr_en;
    logic             drop;

    // Round-half-up and saturate at DATA_W+1 bits so the rounding carry is kept
    always_comb begin
        sum   = {1'b0, data_in} + SW'(RND);
        rq    = sum >> SHIFT;
        q_res = (rq > SW'(MAXV)) ? {OUT_W{1'b1}} : rq[OUT_W-1:0];
    end

    // Next-state logic for decimation, staging, FIFO bookkeeping and the head word
    always_comb begin
        phase_d    = phase_q;
        stg_vld_d  = 1'b0;
        stg_data_d = stg_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ovf_d      = ovf_q;
        drop_d     = drop_q;
        head_d     = head_q;

        keep = valid_in && (phase_q == '0);
        if (valid_in) begin
            phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
        end
        if (keep) begin
            stg_vld_d  = 1'b1;
            stg_data_d = q_res;
        end

        pop   = valid_q && ready_in;
        wr_en = stg_vld_q && ((level_q < LW'(DEPTH)) || pop);
        drop  = stg_vld_q && !wr_en;

        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
        if (wr_en && !pop)      level_d = level_q + LW'(1);
        else if (pop && !wr_en) level_d = level_q - LW'(1);

        if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end

        // The word written this edge lands at wr_ptr_q; bypass it if it becomes the head
        if (level_d != '0) begin
            if (wr_en && (rd_ptr_d == wr_ptr_q)) head_d = stg_data_q;
            else                                 head_d = mem_q[rd_ptr_d];
        end

        valid_d = (level_d != '0);
        full_d  = (level_d == LW'(DEPTH));
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= '0;
            stg_vld_q  <= 1'b0;
            stg_data_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            valid_q    <= 1'b0;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            drop_q     <= '0;
            head_q     <= '0;
        end else begin
            phase_q    <= phase_d;
            stg_vld_q  <= stg_vld_d;
            stg_data_q <= stg_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            valid_q    <= valid_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
            head_q     <= head_d;
        end
    end

    // FIFO storage; contents need no reset because pointers define validity
    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem_q[wr_ptr_q] <= stg_data_q;
    end

    assign data_out  = head_q;
    assign valid_out = valid_q;
    assign level     = level_q;
    assign full      = full_q;
    assign overflow  = ovf_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Scoreboard bench for fir_decim_fifo with three configurations:
// a: SHIFT=7 DECIM=1, b: SHIFT=7 DECIM=2, c: SHIFT=0 DECIM=1.
module tb_fir_decim_fifo;

    logic       clk = 1'b0;
    logic       rst;

    logic [14:0] a_din, b_din, c_din;
    logic        a_vld, b_vld, c_vld;
    logic        a_rdy, b_rdy, c_rdy;
    logic [7:0]  a_dout, b_dout, c_dout;
    logic        a_vo, b_vo, c_vo;
    logic [3:0]  a_lvl, b_lvl, c_lvl;
    logic        a_full, b_full, c_full;
    logic        a_ovf, b_ovf, c_ovf;
    logic [7:0]  a_drop, b_drop, c_drop;

    int qa[$];
    int qb[$];
    int qc[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_decim_fifo #(.DATA_W(15), .OUT_W(8), .SHIFT(7), .DECIM(1), .DEPTH(8)) u_a (
        .clk(clk), .rst(rst), .data_in(a_din), .valid_in(a_vld),
        .data_out(a_dout), .valid_out(a_vo), .ready_in(a_rdy), .level(a_lvl),
        .full(a_full), .overflow(a_ovf), .drop_cnt(a_drop));

    fir_decim_fifo #(.DATA_W(15), .OUT_W(8), .SHIFT(7), .DECIM(2), .DEPTH(8)) u_b (
        .clk(clk), .rst(rst), .data_in(b_din), .valid_in(b_vld),
        .data_out(b_dout), .valid_out(b_vo), .ready_in(b_rdy), .level(b_lvl),
        .full(b_full), .overflow(b_ovf), .drop_cnt(b_drop));

    fir_decim_fifo #(.DATA_W(15), .OUT_W(8), .SHIFT(0), .DECIM(1), .DEPTH(8)) u_c (
        .clk(clk), .rst(rst), .data_in(c_din), .valid_in(c_vld),
        .data_out(c_dout), .valid_out(c_vo), .ready_in(c_rdy), .level(c_lvl),
        .full(c_full), .overflow(c_ovf), .drop_cnt(c_drop));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: every accepted output word is compared against the scoreboard head
    always @(negedge clk) begin
        if (!rst && a_vo && a_rdy) begin
            if (qa.size() == 0) chk("a_unexpected_word", int'(a_dout), -1);
            else                chk("a_data", int'(a_dout), qa.pop_front());
        end
    end
    always @(negedge clk) begin
        if (!rst && b_vo && b_rdy) begin
            if (qb.size() == 0) chk("b_unexpected_word", int'(b_dout), -1);
            else                chk("b_data", int'(b_dout), qb.pop_front());
        end
    end
    always @(negedge clk) begin
        if (!rst && c_vo && c_rdy) begin
            if (qc.size() == 0) chk("c_unexpected_word", int'(c_dout), -1);
            else                chk("c_data", int'(c_dout), qc.pop_front());
        end
    end

    // Present one sample for one clock edge on instance i; valid stays up for chaining
    task automatic send(input int i, input int data);
        case (i)
            0: begin a_din = 15'(data); a_vld = 1'b1; end
            1: begin b_din = 15'(data); b_vld = 1'b1; end
            default: begin c_din = 15'(data); c_vld = 1'b1; end
        endcase
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        a_vld = 1'b0; b_vld = 1'b0; c_vld = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain_a();
        for (int n = 0; n < 50 && a_lvl != 4'd0; n++) @(posedge clk);
        @(negedge clk);
        chk("a_drain_level", int'(a_lvl), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_din = '0; b_din = '0; c_din = '0;
        a_vld = 1'b0; b_vld = 1'b0; c_vld = 1'b0;
        a_rdy = 1'b1; b_rdy = 1'b1; c_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_a_data_out", int'(a_dout), 0);
        chk("rst_a_valid_out", int'(a_vo), 0);
        chk("rst_a_level", int'(a_lvl), 0);
        chk("rst_a_full", int'(a_full), 0);
        chk("rst_a_overflow", int'(a_ovf), 0);
        chk("rst_a_drop_cnt", int'(a_drop), 0);
        chk("rst_b_valid_out", int'(b_vo), 0);
        chk("rst_c_level", int'(c_lvl), 0);
        rst = 1'b0;
        idle(1);

        // Latency and rounding on config a: one cycle visible after the stage edge
        begin
            int din [4] = '{63, 64, 191, 32767};
            int dexp[4] = '{0, 1, 1, 255};
            for (int k = 0; k < 4; k++) begin
                qa.push_back(dexp[k]);
                send(0, din[k]);
                a_vld = 1'b0;
                @(negedge clk);
                chk("a_lat_stage_vo", int'(a_vo), 0);
                @(negedge clk);
                chk("a_lat_write_vo", int'(a_vo), 1);
                @(negedge clk);
                chk("a_lat_popped_vo", int'(a_vo), 0);
            end
        end
        chk("a_no_overflow", int'(a_ovf), 0);

        // Decimation by 2 on config b, including an odd-length burst
        qb.push_back(2); qb.push_back(6);
        send(1, 256); send(1, 512); send(1, 768); send(1, 1024);
        idle(2);
        qb.push_back(1); qb.push_back(3);
        send(1, 128); send(1, 256); send(1, 384);
        idle(2);
        qb.push_back(7);
        send(1, 640); send(1, 896);
        idle(3);
        chk("b_level_after_decim", int'(b_lvl), 0);

        // Fill config a with the consumer stalled; samples 9 and 10 are dropped
        a_rdy = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (i <= 8) qa.push_back(i);
            send(0, 128 * i);
        end
        idle(2);
        @(negedge clk);
        chk("a_full_level", int'(a_lvl), 8);
        chk("a_full_flag", int'(a_full), 1);
        chk("a_overflow_set", int'(a_ovf), 1);
        chk("a_drop_cnt", int'(a_drop), 2);

        // Pop and write in the same edge while full: no drop, new word goes last
        qa.push_back(9);
        send(0, 1152);
        a_vld = 1'b0;
        a_rdy = 1'b1;
        @(posedge clk); #1;
        a_rdy = 1'b0;
        @(negedge clk);
        chk("a_popwrite_level", int'(a_lvl), 8);
        chk("a_popwrite_drop", int'(a_drop), 2);
        a_rdy = 1'b1;
        drain_a();
        chk("a_drain_valid", int'(a_vo), 0);
        chk("a_overflow_sticky", int'(a_ovf), 1);

        // Reset mid-stream with five words buffered and one sample staged
        @(posedge clk); #1;
        a_rdy = 1'b0;
        for (int i = 11; i <= 15; i++) send(0, 128 * i);
        idle(2);
        @(negedge clk);
        chk("a_prerst_level", int'(a_lvl), 5);
        send(0, 2048);
        a_vld = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("a_midrst_level", int'(a_lvl), 0);
        chk("a_midrst_valid", int'(a_vo), 0);
        chk("a_midrst_overflow", int'(a_ovf), 0);
        chk("a_midrst_drop", int'(a_drop), 0);
        chk("a_midrst_full", int'(a_full), 0);
        rst = 1'b0;
        a_rdy = 1'b1;
        idle(4);
        chk("a_postrst_level", int'(a_lvl), 0);
        // Config b left phase at 1; after reset the first sample must be kept
        qb.push_back(10);
        send(1, 1280);
        idle(3);

        // Pass-through saturation on config c
        qc.push_back(255); qc.push_back(255); qc.push_back(0); qc.push_back(255);
        send(2, 255); send(2, 256); send(2, 0); send(2, 32767);
        idle(4);

        @(negedge clk);
        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        chk("c_queue_empty", qc.size(), 0);
        chk("c_final_level", int'(c_lvl), 0);
        chk("c_overflow", int'(c_ovf), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
